// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT butterfly scheduler.
// Optional latency self-check is enabled with NTT_LAT_CHECK_EN.
package ntt_pkg;

  localparam int Q        = 12289;
  localparam int THREE_Q  = 36867;
  localparam int N_DEF    = 1024;
  localparam int LOGN_DEF = 10;

  // Tag address fields are sized for the largest supported transform; only the
  // low ADDR_W bits carry meaning.
  localparam int TAG_AW = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_AW-1:0] addr_a;
    logic [TAG_AW-1:0] addr_b;
  } tag_t;

endpackage

// File: rtl/ntt_tag_delay_line.sv
// Enable-gated shift line tracking in-flight butterflies; reports a
// pre-output valid (for bf_load) and empty / nearly-empty status.
module ntt_tag_delay_line
  import ntt_pkg::*;
#(
  parameter int DEPTH = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  tag_t tag_in,
  output tag_t tag_out,
  output logic pre_valid,
  output logic empty,
  output logic near_empty
);

  tag_t line [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) line[i] <= '0;
    end else if (en) begin
      line[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) line[i] <= line[i-1];
    end
  end

  assign tag_out   = line[DEPTH-1];
  assign pre_valid = line[DEPTH-2].valid;

  // near_empty: only the output slot may still hold a tag, so one more shift drains it
  always_comb begin
    empty      = 1'b1;
    near_empty = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      if (line[i].valid) begin
        empty = 1'b0;
        if (i < DEPTH-1) near_empty = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ntt_butterfly_scheduler.sv
// Stage-by-stage butterfly address / twiddle sequencer for an in-place NTT.
// Define NTT_LAT_CHECK_EN to compare bf_valid against the tag line (sticky err).
module ntt_butterfly_scheduler
  import ntt_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int LOGN     = LOGN_DEF,
  parameter int ADDR_W   = LOGN,
  parameter int PIPE_LAT = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    hold,
  input  logic                    bf_valid,
  output logic                    rd_en,
  output logic [ADDR_W-1:0]       rd_addr_a,
  output logic [ADDR_W-1:0]       rd_addr_b,
  output logic [LOGN-2:0]         omega_idx,
  output logic                    pipe_en,
  output logic                    bf_load,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr_a,
  output logic [ADDR_W-1:0]       wr_addr_b,
  output logic [$clog2(LOGN)-1:0] stage,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int SW = $clog2(LOGN);
  localparam int JW = LOGN - 1;
  localparam logic [SW-1:0] LAST_STAGE = SW'(LOGN-1);
  localparam logic [JW-1:0] LAST_J     = JW'(N/2-1);

  state_t state, state_n;
  logic [JW-1:0]     j;
  logic              issue, drained, last_j;
  logic [ADDR_W-1:0] jx, off, grp, addr_a;
  tag_t              tag_in, tag_out;
  logic              pre_valid, empty, near_empty;
  logic [2*TAG_AW-1:0] unused_tag_addr;

  ntt_tag_delay_line #(.DEPTH(PIPE_LAT)) u_tags (
    .clk        (clk),
    .reset      (reset),
    .en         (!hold),
    .tag_in     (tag_in),
    .tag_out    (tag_out),
    .pre_valid  (pre_valid),
    .empty      (empty),
    .near_empty (near_empty)
  );

  // Leaving DRAIN on the shift that retires the last tag lets the next stage's
  // first read land in the cycle right after the last write-back.
  assign drained = empty || (!hold && near_empty);
  assign last_j  = (j == LAST_J);

  always_comb begin
    state_n = state;
    issue   = 1'b0;
    case (state)
      IDLE:  if (start) state_n = ISSUE;
      ISSUE: if (!hold) begin
               issue = 1'b1;
               if (last_j) state_n = DRAIN;
             end
      DRAIN: if (drained) state_n = (stage == LAST_STAGE) ? DONE : ISSUE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      stage <= '0;
      j     <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        stage <= '0;
        j     <= '0;
      end
      if (issue) j <= last_j ? '0 : j + JW'(1);
      if (state == DRAIN && drained && stage != LAST_STAGE) stage <= stage + SW'(1);
    end
  end

  // j splits into (group, offset) around bit s; the group index is then spread by 2d
  always_comb begin
    jx     = ADDR_W'(j);
    off    = jx & ((ADDR_W'(1) << stage) - ADDR_W'(1));
    grp    = jx >> stage;
    addr_a = ((grp << stage) << 1) | off;
  end

  assign rd_en     = issue;
  assign rd_addr_a = issue ? addr_a : '0;
  assign rd_addr_b = issue ? addr_a + (ADDR_W'(1) << stage) : '0;
  assign omega_idx = issue ? JW'(off << ((LOGN-1) - int'(stage))) : '0;

  assign tag_in = '{valid: issue, addr_a: TAG_AW'(rd_addr_a), addr_b: TAG_AW'(rd_addr_b)};

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign pipe_en   = busy && !hold;
  assign bf_load   = pre_valid && !hold;
  assign wr_en     = tag_out.valid && !hold;
  assign wr_addr_a = tag_out.addr_a[ADDR_W-1:0];
  assign wr_addr_b = tag_out.addr_b[ADDR_W-1:0];
  assign unused_tag_addr = {tag_out.addr_a, tag_out.addr_b};

`ifdef NTT_LAT_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) err <= 1'b0;
    else if (!hold && (bf_valid != tag_out.valid)) err <= 1'b1;
  end
`else
  logic unused_bf_valid;
  assign unused_bf_valid = bf_valid;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_butterfly_scheduler.sv
// Scoreboard bench for ntt_butterfly_scheduler (N=8): expected reads come from a
// loop-form NTT model; writes/loads are checked against unstalled-cycle latency.
module tb_ntt_butterfly_scheduler;

  localparam int N     = 8;
  localparam int LOGN  = 3;
  localparam int AW    = 3;
  localparam int PL    = 6;
  localparam int SW    = $clog2(LOGN);
  localparam int TOTAL = LOGN * (N/2 + PL);
  localparam int RDW   = 2*AW + (LOGN-1) + SW;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, hold = 1'b0;
  logic bf_valid, bfv_rand = 1'b0, wr_en_d = 1'b0, late_mode = 1'b0;
  logic rd_en, pipe_en, bf_load, wr_en, busy, done, err;
  logic [AW-1:0]   rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [LOGN-2:0] omega_idx;
  logic [SW-1:0]   stage;
  logic [7+4*AW+(LOGN-1)+SW-1:0] outs;

  typedef struct {
    logic [AW-1:0]   a, b;
    logic [LOGN-2:0] w;
    logic [SW-1:0]   s;
  } rd_t;
  typedef struct {
    logic [AW-1:0] a, b;
    logic [SW-1:0] s;
    longint        due;
  } wr_t;

  rd_t    rdq[$];
  wr_t    wrq[$];
  longint loadq[$];
  rd_t    r;
  wr_t    w;
  longint l, ucnt = 0;
  int     passed = 0, total = 0, ubusy = 0, stale;
  bit     busy_exp = 1'b0, await_first = 1'b0, done_seen = 1'b0;
  logic [RDW-1:0] got_rd, exp_rd;

  ntt_butterfly_scheduler #(.N(N), .LOGN(LOGN), .ADDR_W(AW), .PIPE_LAT(PL)) dut (
    .clk(clk), .reset(reset), .start(start), .hold(hold), .bf_valid(bf_valid),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .omega_idx(omega_idx),
    .pipe_en(pipe_en), .bf_load(bf_load), .wr_en(wr_en), .wr_addr_a(wr_addr_a),
    .wr_addr_b(wr_addr_b), .stage(stage), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  assign outs = {rd_en, wr_en, bf_load, pipe_en, busy, done, err,
                 rd_addr_a, rd_addr_b, omega_idx, wr_addr_a, wr_addr_b, stage};

`ifdef NTT_LAT_CHECK_EN
  assign bf_valid = late_mode ? wr_en_d : (hold ? bfv_rand : wr_en);
`else
  assign bf_valid = bfv_rand;
`endif

  always @(posedge clk) begin
    bfv_rand <= 1'($urandom_range(1));
    wr_en_d  <= wr_en;
  end

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Textbook loop order: per stage, walk groups of span 2d, then offsets within a group.
  task automatic push_model();
    for (int s = 0; s < LOGN; s++) begin
      int d = 1 << s;
      for (int g = 0; g < N; g += 2*d)
        for (int o = 0; o < d; o++)
          rdq.push_back('{AW'(g+o), AW'(g+o+d), (LOGN-1)'(o * (N/(2*d))), SW'(s)});
    end
  endtask

  always @(negedge clk) begin
    chk(busy == busy_exp, "busy", longint'(busy), longint'(busy_exp));
    chk(done == (busy_exp && ubusy == TOTAL), "done", longint'(done),
        longint'(busy_exp && ubusy == TOTAL));
    chk(pipe_en == (busy_exp && !hold), "pipe_en", longint'(pipe_en), longint'(busy_exp && !hold));
    if (!late_mode) chk(err == 1'b0, "err_clear", longint'(err), 0);
    if (busy_exp && await_first && !hold) begin
      chk(rd_en == 1'b1, "first_rd_latency", longint'(rd_en), 1);
      await_first = 1'b0;
    end
    if (rd_en) begin
      if (rdq.size() == 0) chk(1'b0, "rd_extra", 1, 0);
      else begin
        r = rdq.pop_front();
        got_rd = {rd_addr_a, rd_addr_b, omega_idx, stage};
        exp_rd = {r.a, r.b, r.w, r.s};
        chk(got_rd == exp_rd, "rd_pair", longint'(got_rd), longint'(exp_rd));
        stale = 0;
        foreach (wrq[i]) if (wrq[i].s < r.s) stale++;
        chk(stale == 0, "stage_barrier", stale, 0);
        wrq.push_back('{r.a, r.b, r.s, ucnt + PL});
        loadq.push_back(ucnt + PL - 1);
      end
    end
    if (wr_en) begin
      if (wrq.size() == 0) chk(1'b0, "wr_extra", 1, 0);
      else begin
        w = wrq.pop_front();
        chk({wr_addr_a, wr_addr_b} == {w.a, w.b}, "wr_addr",
            longint'({wr_addr_a, wr_addr_b}), longint'({w.a, w.b}));
        chk(ucnt == w.due, "wr_latency", ucnt, w.due);
      end
    end
    if (bf_load) begin
      if (loadq.size() == 0) chk(1'b0, "load_extra", 1, 0);
      else begin
        l = loadq.pop_front();
        chk(ucnt == l, "load_latency", ucnt, l);
      end
    end
    if (done && busy_exp) begin
      chk(rdq.size() == 0 && wrq.size() == 0 && loadq.size() == 0, "queues_drained",
          longint'(rdq.size() + wrq.size() + loadq.size()), 0);
      done_seen = 1'b1;
    end
    if (reset) begin
      busy_exp = 1'b0;
      rdq.delete(); wrq.delete(); loadq.delete();
    end else if (!busy_exp) begin
      if (start) begin busy_exp = 1'b1; ubusy = 0; await_first = 1'b1; end
    end else if (ubusy == TOTAL) busy_exp = 1'b0;
    else if (!hold) ubusy++;
    if (!hold) ucnt++;
  end

  task automatic run(input int hold_pct, input int restart_at, input int reset_at,
                     input int hold_at, input int hold_len);
    bit aborted = 1'b0;
    done_seen = 1'b0;
    start = 1'b1;
    push_model();
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 2000 && !done_seen && !aborted; c++) begin
      hold  = (c >= hold_at && c < hold_at + hold_len) || ($urandom_range(99) < hold_pct);
      start = (c == restart_at);
      reset = (c == reset_at);
      @(posedge clk); #1;
      if (c == reset_at) begin
        reset = 1'b0; start = 1'b0; hold = 1'b0;
        @(negedge clk);
        chk(outs == '0, "reset_abort", longint'(outs), 0);
        @(posedge clk); #1;
        aborted = 1'b1;
      end
    end
    start = 1'b0;
    hold  = 1'b0;
    if (!done_seen && !aborted) chk(1'b0, "done_timeout", 0, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk(outs == '0, "reset_state", longint'(outs), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    run(0, -1, -1, -1, 0);           // clean transform
    run(0, -1, -1, 13, 3);           // 3-cycle hold at stage-1 j=2
    run(0, 15, -1, -1, 0);           // ignored start while busy
    run(0, -1, 12, -1, 0);           // abort mid stage 1
    run(0, -1, -1, -1, 0);           // fresh start after abort
    for (int k = 0; k < 4; k++)
      run(25, $urandom_range(2, 40), -1, -1, 0);

`ifdef NTT_LAT_CHECK_EN
    late_mode = 1'b1;
    done_seen = 1'b0;
    start = 1'b1;
    push_model();
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 2000 && !done_seen; c++) begin
      @(negedge clk);
      if (c == 7) chk(err == 1'b0, "err_before_mismatch", longint'(err), 0);
      if (c == 8) chk(err == 1'b1, "err_first_mismatch", longint'(err), 1);
      @(posedge clk); #1;
    end
    if (!done_seen) chk(1'b0, "late_timeout", 0, 1);
    chk(err == 1'b1, "err_sticky", longint'(err), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    late_mode = 1'b0;
    @(negedge clk);
    chk(err == 1'b0, "err_reset", longint'(err), 0);
    @(posedge clk); #1;
`endif

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ntt_butterfly_scheduler.md
Name: ntt_butterfly_scheduler

Overview:
Sequences one full in-place NTT over an N-coefficient RAM. It generates butterfly read-address pairs and twiddle (omega) ROM indices stage by stage, and drives load/en into the pipelined butterfly datapath (add path plus Montgomery subtract-multiply-reduce path). It tracks in-flight operations in a tag delay line so it can issue write-back addresses, and drains the pipeline between stages to avoid read-after-write hazards.

Parameters:
N, 1024, transform length (power of two, >=4)
LOGN, 10, log2(N); number of stages
ADDR_W, 10, coefficient address width (= LOGN)
PIPE_LAT, 6, cycles from rd_en (RAM read issue) to the matching butterfly result being valid; >=2

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
start  in  1  1-cycle pulse; begins transform when idle
hold  in  1  stall request from RAM/datapath; freezes issue and tag pipeline
bf_valid  in  1  valid from butterfly pipeline (Montgomery reducer valid)
rd_en  out  1  coefficient RAM read strobe
rd_addr_a  out  ADDR_W  lower butterfly operand address
rd_addr_b  out  ADDR_W  upper operand address (= rd_addr_a + d)
omega_idx  out  LOGN-1  twiddle ROM index for this butterfly
pipe_en  out  1  datapath enable (= ~hold)
bf_load  out  1  load tag into datapath; PIPE_LAT-1 cycles after rd_en (aligned to RAM data)
wr_en  out  1  write-back strobe for both results
wr_addr_a  out  ADDR_W  write address, sum result
wr_addr_b  out  ADDR_W  write address, reduced difference result
stage  out  $clog2(LOGN)  current stage index
busy  out  1  high from the cycle after start is accepted until done
done  out  1  1-cycle pulse after final write-back
err  out  1  sticky latency-mismatch flag (see optional feature)

Behaviour:
- Reset: state IDLE; all outputs 0; stage=0; tag delay line cleared; counters 0. Reset mid-transform aborts immediately; no further rd_en/wr_en.
- FSM: IDLE -> ISSUE on start. ISSUE -> DRAIN after the issue with j = N/2-1. DRAIN -> ISSUE (stage+1) when the delay line is empty and stage < LOGN-1. DRAIN -> DONE when empty and stage = LOGN-1. DONE -> IDLE after 1 cycle, with done=1 in DONE.
- start when not IDLE: ignored. start and reset in the same cycle: reset wins.
- Indexing, stage s, d = 1<<s, j = 0..N/2-1, one butterfly per unstalled cycle:
  - group = j>>s, off = j & (d-1)
  - rd_addr_a = group*2d + off; rd_addr_b = rd_addr_a + d
  - omega_idx = off << (LOGN-1-s)
- Timing: first rd_en in the cycle after start is sampled. For each rd_en, wr_en with the same addresses follows exactly PIPE_LAT unstalled cycles later, via a PIPE_LAT-deep tag shift line {valid, addr_a, addr_b}.
- hold=1: rd_en=0, wr_en=0, j and the delay line frozen, pipe_en=0. Issue resumes with the same j on release, so no butterfly is lost or duplicated.
- Stage barrier: first rd_en of stage s+1 occurs no earlier than the cycle after the last wr_en of stage s (equal when hold=0).
- Nominal total cycles (hold=0), start to done: LOGN*(N/2+PIPE_LAT)+1.
- Counter j wraps to 0 at stage advance; stage saturates at LOGN-1.

Optional Feature:
- Macro NTT_LAT_CHECK_EN.
- Defined: each unstalled cycle, bf_valid is compared with the delay-line output valid. On mismatch, err is set and stays set until reset.
- Undefined: bf_valid is ignored and err is tied to 0.

Decomposition:
- Package ntt_pkg holds:
  - Q = 12289, THREE_Q = 36867
  - default N/LOGN
  - FSM state enum (IDLE, ISSUE, DRAIN, DONE)
  - tag struct {valid, addr_a, addr_b}
- One natural sub-module: ntt_tag_delay_line, a parameterised enable-gated shift register with an all-empty flag.

Test Plan:
- N=8, LOGN=3, PIPE_LAT=6, hold=0; start at cycle 0:
  - rd_en in cycles 1–4 with pairs (0,1),(2,3),(4,5),(6,7), omega_idx 0,0,0,0
  - wr_en in cycles 7–10 with the same pairs
- Stage 1 issues cycles 11–14: (0,2)w0, (1,3)w2, (4,6)w0, (5,7)w2.
- Stage 2 issues cycles 21–24: (0,4)w0, (1,5)w1, (2,6)w2, (3,7)w3.
- Final wr_en is at cycle 30; done=1 at cycle 31 only; busy falls at cycle 32.
- hold=1 for 3 cycles during stage-1 issue of j=2: the (4,6) issue is delayed 3 cycles, all wr_en are shifted by 3, and no pair is repeated or skipped.
- start pulsed again while busy, at cycle 15: no effect, and the sequence is identical to the clean run.
- reset at cycle 12: the next cycle has all outputs 0 and busy=0; a fresh start reproduces the stage-0 sequence from cycle 1 relative.
- With NTT_LAT_CHECK_EN, drive bf_valid one cycle late: err=1 at the first mismatch and stays 1. Without the macro, err=0 throughout.
